// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: load-size encodings, datapath defaults and the
// MEM/WB control bundle used by the write-back stage.
package pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int AW_DEF   = 5;

    localparam logic [1:0] LD_BYTE = 2'b00;
    localparam logic [1:0] LD_HALF = 2'b01;
    localparam logic [1:0] LD_WORD = 2'b10;

    // Width-independent MEM/WB fields; the XLEN/AW-sized fields live beside it
    // so the stage stays parameterisable.
    typedef struct packed {
        logic       valid;
        logic       reg_write;
        logic       to_reg;
        logic [1:0] ld_size;
        logic       ld_unsigned;
    } mem_wb_t;

endpackage

// File: rtl/load_ext.sv
// Combinational load aligner: picks the little-endian byte/half lane selected
// by the address offset and sign- or zero-extends it to XLEN.
module load_ext
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [1:0]      size,
    input  logic            ld_unsigned,
    output logic [XLEN-1:0] ext
);

    logic [31:0] word;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign word      = rdata[31:0];
    assign byte_lane = 8'(word >> {off, 3'b000});
    // off[0] is ignored for halves: a misaligned half reads the aligned lane.
    assign half_lane = off[1] ? word[31:16] : word[15:0];

    // NOTE: ext gets a full default first so every path assigns it and no latch is inferred.
    always_comb begin
        ext = '0;
        unique case (size)
            LD_BYTE: begin
                ext       = {XLEN{~ld_unsigned & byte_lane[7]}};
                ext[7:0]  = byte_lane;
            end
            LD_HALF: begin
                ext       = {XLEN{~ld_unsigned & half_lane[15]}};
                ext[15:0] = half_lane;
            end
            default: begin
                ext       = {XLEN{~ld_unsigned & word[31]}};
                ext[31:0] = word;
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, result select onto the register
// file write port, write-to-read bypass for decode, and retired-instruction count.
module wb_stage
    import pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int AW    = AW_DEF,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic             mem_to_reg,
    input  logic [1:0]       mem_ld_size,
    input  logic             mem_ld_unsigned,
    input  logic [AW-1:0]    mem_rd,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic [AW-1:0]    rf_a3,
    output logic [XLEN-1:0]  rf_wd,
    output logic             rf_we,
    input  logic [AW-1:0]    dec_a1,
    input  logic [AW-1:0]    dec_a2,
    input  logic [XLEN-1:0]  dec_rd1_in,
    input  logic [XLEN-1:0]  dec_rd2_in,
    output logic [XLEN-1:0]  dec_rd1,
    output logic [XLEN-1:0]  dec_rd2,
    output logic             wb_valid,
    output logic [CNT_W-1:0] instret
);

    mem_wb_t         wb_ctrl;
    logic [AW-1:0]   wb_rd;
    logic [XLEN-1:0] wb_alu_result;
    logic [XLEN-1:0] wb_rdata;
    logic [XLEN-1:0] ext_load;

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_ctrl       <= '0;
            wb_rd         <= '0;
            wb_alu_result <= '0;
            wb_rdata      <= '0;
            instret       <= '0;
        end else begin
            // The instruction held in WB retires on this edge only if it is
            // neither squashed nor held.
            if (wb_ctrl.valid && !stall && !flush)
                instret <= instret + CNT_W'(1);

            if (flush) begin
                wb_ctrl.valid     <= 1'b0;
                wb_ctrl.reg_write <= 1'b0;
            end else if (!stall) begin
                wb_ctrl.valid       <= mem_valid;
                wb_ctrl.reg_write   <= mem_reg_write;
                wb_ctrl.to_reg      <= mem_to_reg;
                wb_ctrl.ld_size     <= mem_ld_size;
                wb_ctrl.ld_unsigned <= mem_ld_unsigned;
                wb_rd               <= mem_rd;
                wb_alu_result       <= mem_alu_result;
                wb_rdata            <= mem_rdata;
            end
        end
    end

    load_ext #(.XLEN(XLEN)) u_load_ext (
        .rdata       (wb_rdata),
        .off         (wb_alu_result[1:0]),
        .size        (wb_ctrl.ld_size),
        .ld_unsigned (wb_ctrl.ld_unsigned),
        .ext         (ext_load)
    );

    assign wb_valid = wb_ctrl.valid;
    assign rf_a3    = wb_rd;
    assign rf_wd    = wb_ctrl.to_reg ? ext_load : wb_alu_result;
    // r0 is hard-wired to zero, so its writes are dropped here and never bypassed.
    assign rf_we    = wb_ctrl.valid & wb_ctrl.reg_write & (wb_rd != '0);

    // The register file reads the old value during its write cycle; forward the new one.
    assign dec_rd1 = (rf_we && dec_a1 == rf_a3) ? rf_wd : dec_rd1_in;
    assign dec_rd2 = (rf_we && dec_a2 == rf_a3) ? rf_wd : dec_rd2_in;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: scoreboard of expected write-port values
// plus a small retire-count model tracked edge by edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush;
    logic        mem_valid, mem_reg_write, mem_to_reg, mem_ld_unsigned;
    logic [1:0]  mem_ld_size;
    logic [4:0]  mem_rd;
    logic [31:0] mem_alu_result, mem_rdata;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic        rf_we;
    logic [4:0]  dec_a1, dec_a2;
    logic [31:0] dec_rd1_in, dec_rd2_in, dec_rd1, dec_rd2;
    logic        wb_valid;
    logic [31:0] instret;

    typedef struct {
        logic        we;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        valid;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] exp_cnt = '0;
    logic        model_valid = 1'b0;

    wb_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .mem_valid       (mem_valid),
        .mem_reg_write   (mem_reg_write),
        .mem_to_reg      (mem_to_reg),
        .mem_ld_size     (mem_ld_size),
        .mem_ld_unsigned (mem_ld_unsigned),
        .mem_rd          (mem_rd),
        .mem_alu_result  (mem_alu_result),
        .mem_rdata       (mem_rdata),
        .rf_a3           (rf_a3),
        .rf_wd           (rf_wd),
        .rf_we           (rf_we),
        .dec_a1          (dec_a1),
        .dec_a2          (dec_a2),
        .dec_rd1_in      (dec_rd1_in),
        .dec_rd2_in      (dec_rd2_in),
        .dec_rd1         (dec_rd1),
        .dec_rd2         (dec_rd2),
        .wb_valid        (wb_valid),
        .instret         (instret)
    );

    always #5 clk = ~clk;

    // One clock edge; the retire/valid model sees the same pre-edge inputs as the DUT.
    task automatic tick();
        logic cnt_en;
        cnt_en = model_valid && !stall && !flush && !rst;
        @(posedge clk);
        if (rst) begin
            exp_cnt     = '0;
            model_valid = 1'b0;
        end else begin
            if (cnt_en) exp_cnt = exp_cnt + 32'd1;
            if (flush) model_valid = 1'b0;
            else if (!stall) model_valid = mem_valid;
        end
        #1;
    endtask

    task automatic bubble();
        mem_valid = 1'b0; mem_reg_write = 1'b0; mem_to_reg = 1'b0;
        mem_ld_size = 2'b10; mem_ld_unsigned = 1'b0;
        mem_rd = '0; mem_alu_result = '0; mem_rdata = '0;
    endtask

    // Drive one MEM-stage instruction and push what WB must present one edge later.
    task automatic issue(input logic rw, input logic to_reg, input logic [1:0] size,
                         input logic uns, input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] exp_wd);
        exp_t e;
        mem_valid = 1'b1; mem_reg_write = rw; mem_to_reg = to_reg;
        mem_ld_size = size; mem_ld_unsigned = uns; mem_rd = rd;
        mem_alu_result = alu; mem_rdata = rdata;
        e.we = rw && (rd != 0); e.a3 = rd; e.wd = exp_wd; e.valid = 1'b1;
        sb.push_back(e);
    endtask

    task automatic sb_pop_compare(input string name);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        e = sb.pop_front();
        if (rf_we !== e.we || rf_a3 !== e.a3 || rf_wd !== e.wd || wb_valid !== e.valid) begin
            miscompares++;
            $display("FAIL %s: got we=%b a3=%0d wd=%h valid=%b, expected we=%b a3=%0d wd=%h valid=%b",
                     name, rf_we, rf_a3, rf_wd, wb_valid, e.we, e.a3, e.wd, e.valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        dec_a1 = '0; dec_a2 = '0; dec_rd1_in = '0; dec_rd2_in = '0;
        bubble();
        tick(); tick();
        rst = 1'b0;
        vectors++;
        if ({rf_we, rf_a3, rf_wd, wb_valid} !== '0 || instret !== 32'd0) begin
            miscompares++;
            $display("FAIL reset: got we=%b a3=%0d wd=%h valid=%b instret=%0d, expected all zero",
                     rf_we, rf_a3, rf_wd, wb_valid, instret);
        end
    endtask

    task automatic test_alu_write();
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd5, 32'h0000_1234, 32'h0, 32'h0000_1234);
        tick();
        bubble();
        sb_pop_compare("alu_write");
        vectors++;
        if (instret !== 32'd0) begin
            miscompares++;
            $display("FAIL alu_instret0: got %0d expected 0", instret);
        end
        tick();
        vectors++;
        if (instret !== 32'd1 || instret !== exp_cnt) begin
            miscompares++;
            $display("FAIL alu_instret1: got %0d expected 1 (model %0d)", instret, exp_cnt);
        end
    endtask

    // Loads issued back to back; each result appears one edge after issue.
    task automatic test_load_ext();
        logic [1:0]  sz [8]  = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
        logic        un [8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [1:0]  of [8]  = '{2'd2, 2'd2, 2'd2, 2'd1, 2'd0, 2'd1, 2'd0, 2'd3};
        logic [31:0] ex [8]  = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_80FF, 32'h80FF_7F01,
                                 32'h0000_0001, 32'h0000_007F, 32'h0000_7F01, 32'h0000_80FF};
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, 1'b1, sz[i], un[i], 5'd10, {28'h0000100, 2'b00, of[i]},
                  32'h80FF_7F01, ex[i]);
            tick();
            sb_pop_compare($sformatf("load_%0d", i));
        end
        bubble();
        tick();
    endtask

    task automatic test_r0();
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd0, 32'h0000_DEAD, 32'h0, 32'h0000_DEAD);
        dec_a1 = 5'd0; dec_rd1_in = 32'h0;
        dec_a2 = 5'd0; dec_rd2_in = 32'h0000_0055;
        tick();
        bubble();
        sb_pop_compare("r0_write");
        vectors++;
        if (dec_rd1 !== 32'h0 || dec_rd2 !== 32'h0000_0055) begin
            miscompares++;
            $display("FAIL r0_bypass: got rd1=%h rd2=%h expected rd1=00000000 rd2=00000055",
                     dec_rd1, dec_rd2);
        end
        tick();
    endtask

    task automatic test_bypass();
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd7, 32'hAAAA_5555, 32'h0, 32'hAAAA_5555);
        dec_a1 = 5'd7; dec_rd1_in = 32'd7;
        dec_a2 = 5'd8; dec_rd2_in = 32'd8;
        tick();
        mem_valid = 1'b0;
        sb_pop_compare("bypass_write");
        vectors++;
        if (dec_rd1 !== 32'hAAAA_5555 || dec_rd2 !== 32'd8) begin
            miscompares++;
            $display("FAIL bypass: got rd1=%h rd2=%h expected rd1=aaaa5555 rd2=00000008",
                     dec_rd1, dec_rd2);
        end
        tick();
        vectors++;
        if (dec_rd1 !== 32'd7) begin
            miscompares++;
            $display("FAIL bypass_bubble: got rd1=%h expected 00000007", dec_rd1);
        end
        bubble();
        tick();
    endtask

    task automatic test_stall();
        logic [31:0] snap;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd3, 32'h0000_3333, 32'h0, 32'h0000_3333);
        tick();
        sb_pop_compare("stall_capture");
        snap = instret;
        stall = 1'b1;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd9, 32'h0000_9999, 32'h0, 32'h0);
        void'(sb.pop_back());
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (rf_we !== 1'b1 || rf_a3 !== 5'd3 || rf_wd !== 32'h0000_3333 ||
                instret !== snap || instret !== exp_cnt) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got we=%b a3=%0d wd=%h instret=%0d expected we=1 a3=3 wd=00003333 instret=%0d",
                         i, rf_we, rf_a3, rf_wd, instret, snap);
            end
        end
        stall = 1'b0;
        bubble();
        tick();
        vectors++;
        if (instret !== snap + 32'd1 || instret !== exp_cnt) begin
            miscompares++;
            $display("FAIL stall_release: got instret=%0d expected %0d", instret, snap + 32'd1);
        end
        tick();
    endtask

    task automatic test_flush_reset();
        logic [31:0] snap;
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd4, 32'h0000_4444, 32'h0, 32'h0000_4444);
        tick();
        sb_pop_compare("flush_capture");
        snap = instret;
        flush = 1'b1; stall = 1'b1;
        issue(1'b1, 1'b1, 2'b10, 1'b0, 5'd11, 32'h0000_BBBB, 32'h0, 32'h0);
        void'(sb.pop_back());
        tick();
        flush = 1'b0; stall = 1'b0;
        vectors++;
        if (wb_valid !== 1'b0 || rf_we !== 1'b0 || instret !== snap || instret !== exp_cnt) begin
            miscompares++;
            $display("FAIL flush: got valid=%b we=%b instret=%0d expected valid=0 we=0 instret=%0d",
                     wb_valid, rf_we, instret, snap);
        end
        issue(1'b1, 1'b0, 2'b10, 1'b0, 5'd6, 32'h0000_6666, 32'h0, 32'h0000_6666);
        tick();
        sb_pop_compare("pre_reset_write");
        rst = 1'b1;
        issue(1'b1, 1'b1, 2'b10, 1'b0, 5'd12, 32'h0000_CCCC, 32'h0, 32'h0);
        void'(sb.pop_back());
        tick();
        rst = 1'b0;
        bubble();
        vectors++;
        if ({rf_we, rf_a3, rf_wd, wb_valid} !== '0 || instret !== 32'd0 || exp_cnt !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset: got we=%b a3=%0d wd=%h valid=%b instret=%0d expected all zero",
                     rf_we, rf_a3, rf_wd, wb_valid, instret);
        end
    endtask

    initial begin
        test_reset();
        test_alu_write();
        test_load_ext();
        test_r0();
        test_bypass();
        test_stall();
        test_flush_reset();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Write-back stage of the 5-stage pipeline; it drives the register file's write port (A3/WD/RFW).
- Holds the MEM/WB pipeline register. Selects between the ALU result and sign/zero-extended load data.
- Provides write-to-read bypass to the decode read ports, because the register file's asynchronous read returns the old value during the write cycle.
- Counts retired instructions.

Parameters:
XLEN, 32, datapath width
AW, 5, register address width (2^AW registers)
CNT_W, 32, retired-instruction counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hold MEM/WB register contents
flush  in  1  squash MEM/WB register (insert bubble)
mem_valid  in  1  MEM stage holds a valid instruction
mem_reg_write  in  1  instruction writes a register
mem_to_reg  in  1  1 = load data, 0 = ALU result
mem_ld_size  in  2  00 byte, 01 half, 10/11 word
mem_ld_unsigned  in  1  zero-extend load when 1
mem_rd  in  AW  destination register
mem_alu_result  in  XLEN  ALU result / load address
mem_rdata  in  XLEN  data-memory read word
rf_a3  out  AW  register-file write address
rf_wd  out  XLEN  register-file write data
rf_we  out  1  register-file write enable (RFW)
dec_a1  in  AW  decode read address 1
dec_a2  in  AW  decode read address 2
dec_rd1_in  in  XLEN  register-file RD1
dec_rd2_in  in  XLEN  register-file RD2
dec_rd1  out  XLEN  bypassed operand 1
dec_rd2  out  XLEN  bypassed operand 2
wb_valid  out  1  WB stage holds a valid instruction
instret  out  CNT_W  retired-instruction count

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Update priority each rising edge: rst > flush > stall > capture.
- rst: wb_valid=0, all MEM/WB fields=0, instret=0. As a result rf_we=0, rf_a3=0, rf_wd=0.
- flush (not rst): wb_valid=0 and wb_reg_write=0. Other fields are don't-care. Flush beats stall.
- stall (no rst/flush): all MEM/WB fields hold their values.
- Capture: latch all mem_* inputs, with wb_valid<=mem_valid.
- Latency: 1 cycle from MEM inputs to rf_* outputs.
- rf_we = wb_valid & wb_reg_write & (wb_rd != 0). Writes to r0 are always suppressed.
- rf_a3 = wb_rd.
- rf_wd = wb_to_reg ? ext_load : wb_alu_result. This path is combinational from the MEM/WB register.
- During stall the same write is re-presented each cycle; this is idempotent and required.
- Load extension, using little-endian lanes:
  - Byte offset is off = wb_alu_result[1:0].
  - Byte: lane off, i.e. bits [8*off+7 : 8*off].
  - Half: lane off[1], i.e. bits [16*off[1]+15 : 16*off[1]]. off[0] is ignored; misalignment is not trapped here.
  - Word: full word, off ignored.
  - Sign-extend unless wb_ld_unsigned=1, in which case zero-extend.
- Bypass:
  - dec_rd1 = (rf_we && dec_a1==rf_a3) ? rf_wd : dec_rd1_in.
  - dec_rd2 follows the same rule with dec_a2/dec_rd2_in.
  - Address 0 is never bypassed, because rf_we is 0 for rd=0.
- instret increments by 1 on every edge where wb_valid=1, stall=0, flush=0 and rst=0.
  - Bubbles count nothing. Stores and branches with wb_valid=1 count.
  - Wraps modulo 2^CNT_W.
- Flush at the same edge as a retiring instruction: that instruction is not counted.

Decomposition:
- Shared package pipe_pkg holds:
  - load-size encodings LD_BYTE=2'b00, LD_HALF=2'b01, LD_WORD=2'b10
  - XLEN/AW defaults
  - struct type mem_wb_t for the pipeline-register fields
- One sub-module load_ext. It is combinational: inputs rdata, off, size, unsigned; output extended XLEN value.

Test Plan:
1. Reset, then mem_valid=1, reg_write=1, to_reg=0, rd=5, alu=0x1234 -> next cycle rf_we=1, rf_a3=5, rf_wd=0x1234, instret=0, then instret=1 one edge later.
2. Load byte with rdata=0x80FF7F01: alu[1:0]=2, signed -> rf_wd=0xFFFFFFFF. Same with unsigned -> 0x000000FF. Half with off=2, signed -> 0xFFFF80FF. Word -> 0x80FF7F01.
3. rd=0 with reg_write=1, alu=0xDEAD -> rf_we=0. dec_a1=0 with dec_rd1_in=0 -> dec_rd1=0.
4. Bypass: WB writes rd=7 value 0xAAAA5555 while dec_a1=7, dec_rd1_in=7, dec_a2=8, dec_rd2_in=8 -> dec_rd1=0xAAAA5555, dec_rd2=8.
5. Stall held 3 cycles with a valid write in WB:
   - rf_we/rf_a3/rf_wd are stable all 3 cycles and instret does not change.
   - On the release edge instret increments exactly once.
6. Flush and stall asserted together with a valid WB instruction -> next cycle wb_valid=0, rf_we=0, instret unchanged. rst asserted mid-stream -> all outputs 0 next cycle.
